gaus_sincos_gen: RTL and testbench
==================================

GAUS_SINCOS_GEN -- requirements
Module: gaus_sincos_gen

Interface
REQ-001 Parameter pACC_W, default 16: phase accumulator width; legal 11..32.
REQ-002 iclk  in  1  sole clock; all state on rising edge.
REQ-003 ireset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 iclkena  in  1  clock enable; 0 freezes all state.
REQ-005 ival  in  1  input sample valid.
REQ-006 imode  in  1  0 = direct phase, 1 = internal accumulator.
REQ-007 iphase  in  11  direct phase: [10:9] quadrant, [8:0] in-quadrant index.
REQ-008 istep  in  pACC_W  accumulator increment.
REQ-009 otab_clkena  out  1  clock enable to the quarter-wave table.
REQ-010 ocos_addr  out  9  table cos-port address.
REQ-011 osin_addr  out  9  table sin-port address.
REQ-012 icos_tab  in  18  table cos-port data, unsigned; 2-cycle latency from address.
REQ-013 isin_tab  in  18  table sin-port data, unsigned; 2-cycle latency from address.
REQ-014 oval  out  1  output sample valid.
REQ-015 ocos  out  19  signed cosine, two's complement, full scale +/-131071.
REQ-016 osin  out  19  signed sine, two's complement.

Function
REQ-017 Table entry T[k] = round(131071*cos(k*pi/1022)), k = 0..511; T[0] = 131071, T[511] = 0.
REQ-018 Working phase p[10:0] = iphase when imode = 0, else acc[pACC_W-1 -: 11] before update.
REQ-019 When ival = 1 and iclkena = 1 and imode = 1: acc <= acc + istep, modulo 2^pACC_W.
REQ-020 acc holds when imode = 0, when ival = 0, or when iclkena = 0.
REQ-021 With a = p[8:0] and q = p[10:9]: ocos_addr = q[0] ? ~a : a; osin_addr = q[0] ? a : ~a.
REQ-022 Sign flags: neg_cos = q[1] ^ q[0]; neg_sin = q[1].
REQ-023 otab_clkena = iclkena, combinational.
REQ-024 ival, neg_cos and neg_sin travel in a delay line matched to table latency, advancing only when iclkena = 1.
REQ-025 Output register, loaded when iclkena = 1: ocos = neg_cos ? -icos_tab : +icos_tab; osin likewise with neg_sin; oval = delayed ival.
REQ-026 Output fields hold their last value when oval = 0; only oval is guaranteed to drop.
REQ-027 Latency from ival (sampled) to oval: 3 enabled cycles (4 with REQ-032); throughput one sample per enabled cycle, no back-pressure.
REQ-028 A mid-stream imode change takes effect on the next sample; samples already in flight complete unchanged.
REQ-029 Negating a table value of 0 yields 0, never -0 or overflow.

Reset
REQ-030 With ireset = 0: acc = 0, delay-line valids = 0, oval = 0, ocos = 0, osin = 0, sign flags = 0.
REQ-031 Reset mid-stream discards all in-flight samples; the first oval after release corresponds to the first ival sampled after release.

Configuration
REQ-032 Macro GAUS_SINCOS_ADDR_REG_EN defined: ocos_addr and osin_addr are registered, under iclkena, reset to 0; latency = 4; delay line is one stage longer.
REQ-033 Macro GAUS_SINCOS_ADDR_REG_EN undefined: addresses are combinational from p; latency = 3.

Verification
REQ-034 Direct mode, iphase = 0x000, ival for 1 cycle -> oval 3 cycles later (4 with the macro); ocos = 131071, osin = 0; ocos_addr = 0, osin_addr = 511.
REQ-035 Direct mode sweep of iphase over 0x000, 0x200, 0x400, 0x600 -> (cos, sin) = (131071, 0), (0, 131071), (-131071, 0), (0, -131071).
REQ-036 Accumulator mode, istep = 0x2000, pACC_W = 16, 8 consecutive ivals -> phases 0x000, 0x100, 0x200, ... 0x700; acc wraps to 0 after the 8th sample.
REQ-037 iclkena toggled 1/0 every cycle during a 10-sample burst -> output sequence identical to the burst run with iclkena = 1, each sample spread over twice the cycles.
REQ-038 ireset pulsed low while 2 samples are in flight -> oval = 0 and ocos = osin = 0 immediately; no stale sample appears after release.
REQ-039 Full 2048-phase direct sweep against a reference model with T[] -> bit-exact match; sin^2 + cos^2 within 0.01% of 131071^2.

Source files
------------

// File: rtl/gaus_sincos_gen_if.sv
// Sample-stream and quarter-wave-table bundle for gaus_sincos_gen.
// The slave side is the generator; the master side is the source/table environment.
interface gaus_sincos_gen_if #(
    parameter int pACC_W = 16
);
    // Handshake: ival qualifies imode/iphase/istep on every edge where iclkena = 1.
    // There is no ready; every such sample is accepted. oval qualifies ocos/osin.
    logic              iclkena;
    logic              ival;
    logic              imode;
    logic [10:0]       iphase;
    logic [pACC_W-1:0] istep;
    logic              otab_clkena;
    logic [8:0]        ocos_addr;
    logic [8:0]        osin_addr;
    logic [17:0]       icos_tab;
    logic [17:0]       isin_tab;
    logic              oval;
    logic [18:0]       ocos;
    logic [18:0]       osin;

    modport master (
        output iclkena, ival, imode, iphase, istep, icos_tab, isin_tab,
        input  otab_clkena, ocos_addr, osin_addr, oval, ocos, osin
    );

    modport slave (
        input  iclkena, ival, imode, iphase, istep, icos_tab, isin_tab,
        output otab_clkena, ocos_addr, osin_addr, oval, ocos, osin
    );
endinterface

// File: rtl/gaus_sincos_gen.sv
// Quarter-wave-table sine/cosine generator with direct or accumulated phase.
// Define GAUS_SINCOS_ADDR_REG_EN to register the table addresses (latency 4 instead of 3).
module gaus_sincos_gen #(
    parameter int pACC_W = 16
) (
    input logic               iclk,
    input logic               ireset,
    gaus_sincos_gen_if.slave  bus
);

`ifdef GAUS_SINCOS_ADDR_REG_EN
    localparam int DL = 3;
`else
    localparam int DL = 2;
`endif

    logic [pACC_W-1:0] acc_q, acc_d;
    logic [DL-1:0]     val_dl_q, val_dl_d;
    logic [DL-1:0]     ncos_dl_q, ncos_dl_d;
    logic [DL-1:0]     nsin_dl_q, nsin_dl_d;
    logic              oval_q, oval_d;
    logic [18:0]       ocos_q, ocos_d;
    logic [18:0]       osin_q, osin_d;

    logic [10:0]       phase;
    logic [1:0]        quad;
    logic [8:0]        idx;
    logic [8:0]        cos_addr;
    logic [8:0]        sin_addr;
    logic [18:0]       cos_ext;
    logic [18:0]       sin_ext;

    // Accumulator mode uses the accumulator value before this sample's update.
    always_comb begin
        phase    = bus.imode ? acc_q[pACC_W-1 -: 11] : bus.iphase;
        quad     = phase[10:9];
        idx      = phase[8:0];
        cos_addr = quad[0] ? ~idx : idx;
        sin_addr = quad[0] ? idx : ~idx;
        cos_ext  = {1'b0, bus.icos_tab};
        sin_ext  = {1'b0, bus.isin_tab};
    end

    always_comb begin
        acc_d     = acc_q;
        val_dl_d  = val_dl_q;
        ncos_dl_d = ncos_dl_q;
        nsin_dl_d = nsin_dl_q;
        oval_d    = oval_q;
        ocos_d    = ocos_q;
        osin_d    = osin_q;
        if (bus.iclkena) begin
            if (bus.ival && bus.imode) begin
                acc_d = acc_q + bus.istep;
            end
            val_dl_d  = {val_dl_q[DL-2:0], bus.ival};
            ncos_dl_d = {ncos_dl_q[DL-2:0], quad[1] ^ quad[0]};
            nsin_dl_d = {nsin_dl_q[DL-2:0], quad[1]};
            oval_d    = val_dl_q[DL-1];
            // Two's-complement negation of a zero table value stays zero.
            ocos_d    = ncos_dl_q[DL-1] ? (~cos_ext + 19'd1) : cos_ext;
            osin_d    = nsin_dl_q[DL-1] ? (~sin_ext + 19'd1) : sin_ext;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            acc_q     <= '0;
            val_dl_q  <= '0;
            ncos_dl_q <= '0;
            nsin_dl_q <= '0;
            oval_q    <= 1'b0;
            ocos_q    <= '0;
            osin_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            val_dl_q  <= val_dl_d;
            ncos_dl_q <= ncos_dl_d;
            nsin_dl_q <= nsin_dl_d;
            oval_q    <= oval_d;
            ocos_q    <= ocos_d;
            osin_q    <= osin_d;
        end
    end

`ifdef GAUS_SINCOS_ADDR_REG_EN
    logic [8:0] cos_addr_q, cos_addr_d;
    logic [8:0] sin_addr_q, sin_addr_d;

    always_comb begin
        cos_addr_d = cos_addr_q;
        sin_addr_d = sin_addr_q;
        if (bus.iclkena) begin
            cos_addr_d = cos_addr;
            sin_addr_d = sin_addr;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            cos_addr_q <= '0;
            sin_addr_q <= '0;
        end else begin
            cos_addr_q <= cos_addr_d;
            sin_addr_q <= sin_addr_d;
        end
    end

    assign bus.ocos_addr = cos_addr_q;
    assign bus.osin_addr = sin_addr_q;
`else
    assign bus.ocos_addr = cos_addr;
    assign bus.osin_addr = sin_addr;
`endif

    assign bus.otab_clkena = bus.iclkena;
    assign bus.oval        = oval_q;
    assign bus.ocos        = ocos_q;
    assign bus.osin        = osin_q;

endmodule

// File: tb/tb_gaus_sincos_gen.sv
// Directed bench for gaus_sincos_gen: quarter-wave table stub, trig-level model, per-cycle compare.
module tb_gaus_sincos_gen;
    localparam int  ACC_W = 16;
    localparam real PI    = 3.14159265358979323846;
`ifdef GAUS_SINCOS_ADDR_REG_EN
    localparam int  LAT = 4;
`else
    localparam int  LAT = 3;
`endif
    localparam longint PWR_REF = 64'd17179607041; // 131071^2
    localparam longint PWR_TOL = 64'd1717960;     // 0.01 %

    logic iclk   = 1'b0;
    logic ireset = 1'b1;

    gaus_sincos_gen_if #(.pACC_W(ACC_W)) bus ();
    gaus_sincos_gen #(.pACC_W(ACC_W)) dut (.iclk(iclk), .ireset(ireset), .bus(bus));

    // ---------------- clock / reset ----------------
    always #5 iclk = ~iclk;

    // ---------------- counters and helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // ---------------- quarter-wave table stub (2-cycle latency) ----------------
    int         tab[512];
    logic [8:0] tc_a, ts_a;

    always @(posedge iclk) begin
        if (bus.otab_clkena) begin
            tc_a         <= bus.ocos_addr;
            ts_a         <= bus.osin_addr;
            bus.icos_tab <= 18'(tab[tc_a]);
            bus.isin_tab <= 18'(tab[ts_a]);
        end
    end

    // ---------------- model ----------------
    // cos/sin of phase p (2048 steps per turn) from quadrant symmetry of the table.
    function automatic void exp_cs(input logic [10:0] p, output int c, output int s);
        int a;
        int b;
        a = int'(p[8:0]);
        b = 511 - a;
        case (p[10:9])
            2'd0: begin c =  tab[a]; s =  tab[b]; end
            2'd1: begin c = -tab[b]; s =  tab[a]; end
            2'd2: begin c = -tab[a]; s = -tab[b]; end
            default: begin c = tab[b]; s = -tab[a]; end
        endcase
    endfunction

    logic [37:0]      exp_q[$];
    int               due_q[$];
    int               en_cnt = 0;
    bit               last_en = 1'b0;
    logic [ACC_W-1:0] m_acc = '0;

    always @(posedge iclk) begin : model_proc
        logic [10:0] p;
        int          c;
        int          s;
        last_en = ireset && bus.iclkena;
        if (ireset && bus.iclkena) begin
            en_cnt++;
            if (bus.ival) begin
                p = bus.imode ? m_acc[ACC_W-1 -: 11] : bus.iphase;
                exp_cs(p, c, s);
                exp_q.push_back({19'(c), 19'(s)});
                due_q.push_back(en_cnt + LAT - 1);
                if (bus.imode) m_acc = m_acc + bus.istep;
            end
        end
    end

    always @(negedge ireset) begin
        exp_q.delete();
        due_q.delete();
        m_acc = '0;
    end

    // ---------------- scoreboard / compare ----------------
    int obs_c[$];
    int obs_s[$];
    int out_cnt = 0;
    int pwr_bad = 0;

    always @(negedge iclk) begin : compare_proc
        logic [37:0] e;
        int          d;
        int          dc;
        int          ds;
        longint      pw;
        if (ireset && last_en) begin
            if (bus.oval) begin
                dc = int'($signed(bus.ocos));
                ds = int'($signed(bus.osin));
                if (exp_q.size() == 0) begin
                    chk("unexpected_oval", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    chk("ocos", dc, int'($signed(e[37:19])));
                    chk("osin", ds, int'($signed(e[18:0])));
                    chk("latency_edge", en_cnt, d);
                end
                pw = longint'(dc) * dc + longint'(ds) * ds;
                if (pw > PWR_REF + PWR_TOL || pw < PWR_REF - PWR_TOL) pwr_bad++;
                obs_c.push_back(dc);
                obs_s.push_back(ds);
                out_cnt++;
            end else if (due_q.size() > 0) begin
                chk("oval_missing", (due_q[0] <= en_cnt) ? 1 : 0, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input bit m, input logic [10:0] ph, input bit en);
        @(negedge iclk);
        #1;
        bus.ival    = v;
        bus.imode   = m;
        bus.iphase  = ph;
        bus.iclkena = en;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 11'h000, 1'b1);
    endtask

    task automatic wait_outs(input int target);
        int guard;
        guard = 0;
        while (out_cnt < target && guard < 100) begin
            @(negedge iclk);
            #2;
            guard++;
        end
        chk("out_count", out_cnt, target);
    endtask

    task automatic chk_obs(input string name, input int i, input int c, input int s);
        chk({name, "_cos"}, (obs_c.size() > i) ? obs_c[i] : 999999, c);
        chk({name, "_sin"}, (obs_s.size() > i) ? obs_s[i] : 999999, s);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_proc
        int c;
        int s;
        int base;
        for (int k = 0; k < 512; k++) begin
            tab[k] = $rtoi(131071.0 * $cos(real'(k) * PI / 1022.0) + 0.5);
        end
        bus.iclkena = 1'b1;
        bus.ival    = 1'b0;
        bus.imode   = 1'b0;
        bus.iphase  = '0;
        bus.istep   = '0;

        // model pins
        chk("tab0", tab[0], 131071);
        chk("tab511", tab[511], 0);
        exp_cs(11'h000, c, s); chk("model_p000_cos", c, 131071);  chk("model_p000_sin", s, 0);
        exp_cs(11'h200, c, s); chk("model_p200_cos", c, 0);       chk("model_p200_sin", s, 131071);
        exp_cs(11'h400, c, s); chk("model_p400_cos", c, -131071); chk("model_p400_sin", s, 0);
        exp_cs(11'h600, c, s); chk("model_p600_cos", c, 0);       chk("model_p600_sin", s, -131071);

        // reset
        #1 ireset = 1'b0;
        repeat (3) @(negedge iclk);
        #1;
        chk("reset_oval", bus.oval, 0);
        chk("reset_ocos", bus.ocos, 0);
        chk("reset_osin", bus.osin, 0);
        ireset = 1'b1;
        idle(2);

        // single direct sample at phase 0, table addresses
        obs_c.delete(); obs_s.delete(); base = out_cnt;
        drive(1'b1, 1'b0, 11'h000, 1'b1);
`ifdef GAUS_SINCOS_ADDR_REG_EN
        @(posedge iclk);
`endif
        #1;
        chk("cos_addr_p0", bus.ocos_addr, 0);
        chk("sin_addr_p0", bus.osin_addr, 511);
        idle(1);
        wait_outs(base + 1);
        chk_obs("single_p0", 0, 131071, 0);

        // quadrant sweep
        obs_c.delete(); obs_s.delete(); base = out_cnt;
        drive(1'b1, 1'b0, 11'h000, 1'b1);
        drive(1'b1, 1'b0, 11'h200, 1'b1);
        drive(1'b1, 1'b0, 11'h400, 1'b1);
        drive(1'b1, 1'b0, 11'h600, 1'b1);
        idle(1);
        wait_outs(base + 4);
        chk_obs("quad0", 0, 131071, 0);
        chk_obs("quad1", 1, 0, 131071);
        chk_obs("quad2", 2, -131071, 0);
        chk_obs("quad3", 3, 0, -131071);

        // accumulator mode, 8 samples then one more after the wrap
        obs_c.delete(); obs_s.delete(); base = out_cnt;
        bus.istep = 16'h2000;
        repeat (9) drive(1'b1, 1'b1, 11'h000, 1'b1);
        idle(1);
        wait_outs(base + 9);
        chk_obs("acc_p200", 2, 0, 131071);
        chk_obs("acc_p400", 4, -131071, 0);
        chk_obs("acc_wrap", 8, 131071, 0);

        // mid-stream mode changes (accumulator now at 0x2000)
        obs_c.delete(); obs_s.delete(); base = out_cnt;
        drive(1'b1, 1'b0, 11'h123, 1'b1);
        drive(1'b1, 1'b1, 11'h000, 1'b1);
        drive(1'b1, 1'b0, 11'h7ff, 1'b1);
        drive(1'b1, 1'b1, 11'h400, 1'b1);
        idle(1);
        wait_outs(base + 4);
        chk_obs("mode_acc_p200", 3, 0, 131071);

        // clock enable toggling during a 10-sample burst
        base = out_cnt;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 11'(k * 205 + 17), 1'b1);
            drive(1'b1, 1'b0, 11'h3ff, 1'b0);
        end
        idle(1);
        wait_outs(base + 10);

        // reset with two samples in flight
        drive(1'b1, 1'b0, 11'h200, 1'b1);
        drive(1'b1, 1'b0, 11'h400, 1'b1);
        @(negedge iclk);
        #1;
        bus.ival = 1'b0;
        ireset   = 1'b0;
        #1;
        chk("midrst_oval", bus.oval, 0);
        chk("midrst_ocos", bus.ocos, 0);
        chk("midrst_osin", bus.osin, 0);
        repeat (2) @(negedge iclk);
        #1 ireset = 1'b1;
        idle(6);
        obs_c.delete(); obs_s.delete(); base = out_cnt;
        drive(1'b1, 1'b0, 11'h600, 1'b1);
        idle(1);
        wait_outs(base + 1);
        chk_obs("post_reset", 0, 0, -131071);

        // full 2048-phase direct sweep
        base = out_cnt;
        for (int k = 0; k < 2048; k++) drive(1'b1, 1'b0, 11'(k), 1'b1);
        idle(1);
        wait_outs(base + 2048);
        chk("power_out_of_tol", pwr_bad, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
